// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the PC, addresses the
// combinational instruction memory and registers the returned word into
// the IF/ID pipeline register. Handles stall, flush, redirect,
// misaligned-target halt and EBREAK halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
  parameter logic [31:0] EBREAK_INSTR = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 10;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } ifid_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  ifid_t           ifid_q, ifid_d;
  logic            halted_d;
  logic            misalign_d;
  logic [XLEN-1:0] count_d;

  // State and pipeline registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      pc_q           <= RESET_PC;
      ifid_q.valid   <= 1'b0;
      ifid_q.pc      <= '0;
      ifid_q.pc_plus4 <= '0;
      ifid_q.instr   <= NOP_INSTR;
      halted         <= 1'b0;
      misalign       <= 1'b0;
      fetch_count    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ifid_q      <= ifid_d;
      halted      <= halted_d;
      misalign    <= misalign_d;
      fetch_count <= count_d;
    end
  end

  // Next-state logic: redirect beats stall beats advance; flush only bubbles IF/ID.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_d     = ifid_q;
    halted_d   = halted;
    misalign_d = misalign;
    count_d    = fetch_count;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          ifid_d.valid = 1'b0;
          ifid_d.instr = NOP_INSTR;
          if (redirect_pc[1:0] != 2'b00) begin
            // Misaligned target: keep PC so the faulting context is visible.
            misalign_d = 1'b1;
            halted_d   = 1'b1;
            state_d    = HALT;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (stall) begin
          if (flush) begin
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
          end
        end else begin
          pc_d = pc_q + XLEN'(4);
          if (flush) begin
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
          end else begin
            ifid_d.valid    = 1'b1;
            ifid_d.pc       = pc_q;
            ifid_d.pc_plus4 = pc_q + XLEN'(4);
            ifid_d.instr    = imem_instr;
            count_d         = fetch_count + XLEN'(1);
            if (imem_instr == EBREAK_INSTR) begin
              halted_d = 1'b1;
              state_d  = HALT;
            end
          end
        end
      end
      HALT: begin
        // Drain: the EBREAK leaves IF/ID and a bubble holds from then on.
        ifid_d.valid = 1'b0;
        ifid_d.instr = NOP_INSTR;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // Memory address is the low PC bits; wraps every 1 KiB.
  assign imem_addr     = pc_q[AW-1:0];
  assign ifid_valid    = ifid_q.valid;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_instr    = ifid_q.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a rule-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk;
  logic        rst;
  logic [9:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        halted;
  logic        misalign;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];

  // Reference model state.
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
  logic        m_v, m_halt, m_mis;

  int n_checks;
  int n_pass;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .stall        (stall),
    .flush        (flush),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_instr   (ifid_instr),
    .halted       (halted),
    .misalign     (misalign),
    .fetch_count  (fetch_count)
  );

  // Combinational word-addressed instruction memory.
  assign imem_instr = mem[imem_addr[9:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h at t=%0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP; m_cnt = 32'h0;
    m_v = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
  endtask

  task automatic model_bubble();
    m_v = 1'b0;
    m_instr = NOP;
  endtask

  // Apply the fetch rules for one rising edge using the current inputs.
  task automatic model_edge();
    logic [31:0] w;
    if (m_halt) begin
      model_bubble();
    end else if (redirect) begin
      model_bubble();
      if (redirect_pc % 4 != 0) begin
        m_halt = 1'b1;
        m_mis  = 1'b1;
      end else begin
        m_pc = redirect_pc;
      end
    end else if (stall) begin
      if (flush) model_bubble();
    end else begin
      w = mem[(m_pc % 1024) / 4];
      if (flush) model_bubble();
      else begin
        m_v = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = w;
        m_cnt = m_cnt + 1;
        if (w == EBREAK) m_halt = 1'b1;
      end
      m_pc = m_pc + 4;
    end
  endtask

  task automatic compare_all();
    check("imem_addr",     {22'd0, imem_addr}, m_pc % 1024);
    check("ifid_valid",    {31'd0, ifid_valid}, {31'd0, m_v});
    check("ifid_pc",       ifid_pc, m_ipc);
    check("ifid_pc_plus4", ifid_pc_plus4, m_ipc4);
    check("ifid_instr",    ifid_instr, m_instr);
    check("halted",        {31'd0, halted}, {31'd0, m_halt});
    check("misalign",      {31'd0, misalign}, {31'd0, m_mis});
    check("fetch_count",   fetch_count, m_cnt);
  endtask

  task automatic set_in(input logic s, input logic f, input logic r, input logic [31:0] rpc);
    stall = s; flush = f; redirect = r; redirect_pc = rpc;
  endtask

  // One clock: sample inputs for the model, step past the edge, compare mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i * 4);
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    model_reset();
    #2;
    compare_all();
    check("reset ifid_instr lit", ifid_instr, 32'h0000_0013);
    check("reset imem_addr lit", {22'd0, imem_addr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Free run two edges, then stall two edges at pc=8.
    tick(); tick();
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    check("stall ifid_pc lit", ifid_pc, 32'h4);
    check("stall ifid_instr lit", ifid_instr, 32'h1000_0004);
    check("stall count lit", fetch_count, 32'd2);
    check("stall addr lit", {22'd0, imem_addr}, 32'h8);
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("resume ifid_pc lit", ifid_pc, 32'h8);
    tick();
    check("run4 ifid_pc lit", ifid_pc, 32'hC);
    check("run4 count lit", fetch_count, 32'd4);
    check("run4 addr lit", {22'd0, imem_addr}, 32'd16);

    // Redirect wins over stall.
    set_in(1'b1, 1'b0, 1'b1, 32'h40);
    tick();
    check("redir valid lit", {31'd0, ifid_valid}, 32'h0);
    check("redir instr lit", ifid_instr, 32'h13);
    check("redir addr lit", {22'd0, imem_addr}, 32'h40);
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("target ifid_pc lit", ifid_pc, 32'h40);
    check("target instr lit", ifid_instr, 32'h1000_0040);
    check("target pc4 lit", ifid_pc_plus4, 32'h44);

    // Flush while advancing, then flush under stall.
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    check("flush count lit", fetch_count, 32'd5);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    tick();

    // Misaligned redirect halts; later stimulus is ignored.
    set_in(1'b0, 1'b0, 1'b1, 32'h42);
    tick();
    check("misalign lit", {31'd0, misalign}, 32'h1);
    check("misalign halted lit", {31'd0, halted}, 32'h1);
    check("misalign addr lit", {22'd0, imem_addr}, 32'h50);
    set_in(1'b0, 1'b0, 1'b1, 32'h100); tick();
    set_in(1'b1, 1'b1, 1'b0, 32'h0);   tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);   tick();
    check("halt frozen addr lit", {22'd0, imem_addr}, 32'h50);
    check("halt frozen count lit", fetch_count, 32'd6);

    // EBREAK at 0x0C halts after being captured.
    do_reset();
    mem[3] = EBREAK;
    tick(); tick(); tick(); tick();
    check("ebreak instr lit", ifid_instr, 32'h0010_0073);
    check("ebreak valid lit", {31'd0, ifid_valid}, 32'h1);
    check("ebreak count lit", fetch_count, 32'd4);
    check("ebreak halted lit", {31'd0, halted}, 32'h1);
    tick();
    check("ebreak drain valid lit", {31'd0, ifid_valid}, 32'h0);
    check("ebreak pc frozen lit", {22'd0, imem_addr}, 32'h10);
    tick();
    mem[3] = 32'h1000_000C;

    // Run past 0x3FC: address wraps while PC does not.
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 32'h3F8);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    check("wrap addr lit", {22'd0, imem_addr}, 32'h0);
    check("wrap pc4 lit", ifid_pc_plus4, 32'h400);
    tick();
    check("wrap ifid_pc lit", ifid_pc, 32'h400);
    check("wrap instr lit", ifid_instr, 32'h1000_0000);

    // Asynchronous reset mid-cycle.
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("async count lit", fetch_count, 32'h0);
    check("async valid lit", {31'd0, ifid_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
